unsigned_mul_8x8_ha_array_reduce: RTL and testbench

Pipelined final-reduction stage for the approximate unsigned 8x8 multiplier. It consumes the four half-adder arrays produced by the partial-product/HA stage (`ha_array_k_t`, `ha_array_k_b`, k=0..3) and produces the 16-bit approximate product. A valid/ready handshake carries each transaction through two register stages, with full backpressure.

---
 rtl/umul8_ha_pkg.sv | 24 ++
 rtl/unsigned_mul_8x8_ha_array_reduce_if.sv | 53 +++++
 rtl/umul8_pipe_slice.sv | 52 +++++
 rtl/unsigned_mul_8x8_ha_array_reduce.sv | 88 ++++++++
 tb/tb_unsigned_mul_8x8_ha_array_reduce.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/umul8_ha_pkg.sv
// -----------------------------------------------------------------------------
// umul8_ha_pkg
// Shared definitions for the approximate unsigned 8x8 multiplier: half-adder
// array geometry and the helper that turns one array (top row + carry row)
// into its unsigned value. Used by the HA-array generator, this reduction
// stage and the checkers.
// -----------------------------------------------------------------------------
package umul8_ha_pkg;

  localparam int HA_T_W  = 9;   // top-row bits per array
  localparam int HA_B_W  = 7;   // carry-row bits per array
  localparam int HA_NARR = 4;   // arrays per operand pair
  localparam int HA_V_W  = 10;  // value of one array, max 511 + 508 = 1019
  localparam int HA_S_W  = 13;  // pair sum V_a + (V_b << 2), max 5095

  // Carry-row bit i sits two places above top-row bit i.
  function automatic logic [HA_V_W-1:0] ha_array_value(
    input logic [HA_T_W-1:0] t,
    input logic [HA_B_W-1:0] b
  );
    return HA_V_W'(t) + HA_V_W'({b, 2'b00});
  endfunction

endpackage

// File: rtl/unsigned_mul_8x8_ha_array_reduce_if.sv
// -----------------------------------------------------------------------------
// unsigned_mul_8x8_ha_array_reduce_if
// Handshake bundle of the final-reduction stage.
//   in_valid / in_ready        : upstream handshake for the four HA arrays
//   ha_array_k_t / ha_array_k_b: top-row and carry-row bits of array k
//   out_valid / out_ready      : downstream handshake for the product
//   out_p / out_ovf            : product (mod 2^P_W) and wrap flag
// master: the side producing arrays and consuming products.
// slave : the reduction stage itself.
// -----------------------------------------------------------------------------
interface unsigned_mul_8x8_ha_array_reduce_if #(
  parameter int P_W = 16
);
  import umul8_ha_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [HA_T_W-1:0] ha_array_0_t;
  logic [HA_T_W-1:0] ha_array_1_t;
  logic [HA_T_W-1:0] ha_array_2_t;
  logic [HA_T_W-1:0] ha_array_3_t;
  logic [HA_B_W-1:0] ha_array_0_b;
  logic [HA_B_W-1:0] ha_array_1_b;
  logic [HA_B_W-1:0] ha_array_2_b;
  logic [HA_B_W-1:0] ha_array_3_b;
  logic              out_valid;
  logic              out_ready;
  logic [P_W-1:0]    out_p;
  logic              out_ovf;

  modport master (
    output in_valid,
    output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_p,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    input  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_p,
    output out_ovf
  );

endinterface

// File: rtl/umul8_pipe_slice.sv
// -----------------------------------------------------------------------------
// umul8_pipe_slice
// One valid/ready register slice of width W. Ready passes straight through:
// the slice accepts whenever it is empty or its content leaves this cycle,
// so chained slices stream one item per cycle with no bubbles.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake, in_data captured on transfer
//   out_valid/out_ready  : downstream handshake, out_data is the register
// -----------------------------------------------------------------------------
module umul8_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;
  logic         load_s;

  // Ready-through: free when empty or when the held item is being taken.
  always_comb begin
    in_ready = !valid_r || out_ready;
    load_s   = in_valid && in_ready;
  end

  // Occupancy and data register; data only changes on a transfer in.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (load_s) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;

endmodule

// File: rtl/unsigned_mul_8x8_ha_array_reduce.sv
// -----------------------------------------------------------------------------
// unsigned_mul_8x8_ha_array_reduce
// Final reduction of the approximate 8x8 multiplier. The four HA arrays are
// valued (V_k), combined pairwise into S01/S23 ahead of the first slice, and
// S01 + (S23 << 4) is formed ahead of the second slice, whose register drives
// the product. Two transactions may be in flight; full backpressure.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, drops everything in flight
//   bus  : slave side of unsigned_mul_8x8_ha_array_reduce_if
// -----------------------------------------------------------------------------
module unsigned_mul_8x8_ha_array_reduce
  import umul8_ha_pkg::*;
#(
  parameter int P_W = 16
) (
  input logic clk,
  input logic rst,
  unsigned_mul_8x8_ha_array_reduce_if.slave bus
);

  localparam int S1_W  = 2 * HA_S_W;
  // The exact sum needs 17 bits; keep at least one bit above P_W for the flag.
  localparam int SUM_W = (P_W + 1 > 17) ? P_W + 1 : 17;

  logic [HA_V_W-1:0] v0_s;
  logic [HA_V_W-1:0] v1_s;
  logic [HA_V_W-1:0] v2_s;
  logic [HA_V_W-1:0] v3_s;
  logic [HA_S_W-1:0] s01_in_s;
  logic [HA_S_W-1:0] s23_in_s;
  logic [S1_W-1:0]   s1_in_s;
  logic [S1_W-1:0]   s1_out_s;
  logic              s1_valid_s;
  logic              s2_ready_s;
  logic [HA_S_W-1:0] s01_s;
  logic [HA_S_W-1:0] s23_s;
  logic [SUM_W-1:0]  sum_s;
  logic              ovf_s;
  logic [P_W:0]      s2_in_s;
  logic [P_W:0]      s2_out_s;

  // Array values and the first-level pair sums (arrays k, k+1 differ by 2^2).
  always_comb begin
    v0_s     = ha_array_value(bus.ha_array_0_t, bus.ha_array_0_b);
    v1_s     = ha_array_value(bus.ha_array_1_t, bus.ha_array_1_b);
    v2_s     = ha_array_value(bus.ha_array_2_t, bus.ha_array_2_b);
    v3_s     = ha_array_value(bus.ha_array_3_t, bus.ha_array_3_b);
    s01_in_s = HA_S_W'(v0_s) + HA_S_W'({v1_s, 2'b00});
    s23_in_s = HA_S_W'(v2_s) + HA_S_W'({v3_s, 2'b00});
    s1_in_s  = {s01_in_s, s23_in_s};
  end

  umul8_pipe_slice #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (s1_in_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_ready_s),
    .out_data  (s1_out_s)
  );

  // Second-level sum (pair 23 sits 2^4 above pair 01) and wrap detection.
  always_comb begin
    s01_s   = s1_out_s[S1_W-1:HA_S_W];
    s23_s   = s1_out_s[HA_S_W-1:0];
    sum_s   = SUM_W'(s01_s) + SUM_W'({s23_s, 4'b0000});
    ovf_s   = (sum_s >> P_W) != {SUM_W{1'b0}};
    s2_in_s = {ovf_s, sum_s[P_W-1:0]};
  end

  umul8_pipe_slice #(.W(P_W + 1)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_ready_s),
    .in_data   (s2_in_s),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_out_s)
  );

  assign bus.out_p   = s2_out_s[P_W-1:0];
  assign bus.out_ovf = s2_out_s[P_W];

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_reduce.sv
// -----------------------------------------------------------------------------
// tb_unsigned_mul_8x8_ha_array_reduce
// Self-checking bench: directed cases followed by random streaming. Expected
// products come from summing individual bit weights; expected handshake state
// comes from the number of items in flight.
// -----------------------------------------------------------------------------
module tb_unsigned_mul_8x8_ha_array_reduce;

  logic clk;
  logic rst;

  unsigned_mul_8x8_ha_array_reduce_if #(.P_W(16)) bus ();

  unsigned_mul_8x8_ha_array_reduce #(.P_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt;
  int chk_cnt;
  int exp_q[$];        // exact sums of accepted transactions, oldest first
  bit acc_last;        // an item was accepted at the most recent edge
  logic [8:0] t_v [4];
  logic [6:0] b_v [4];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Exact value: every set bit contributes its weight.
  function automatic int ref_sum();
    int s = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) if (t_v[k][i]) s += (1 << (2 * k + i));
      for (int i = 0; i < 7; i++) if (b_v[k][i]) s += (1 << (2 * k + i + 2));
    end
    return s;
  endfunction

  task automatic clear_arrays();
    for (int k = 0; k < 4; k++) begin
      t_v[k] = 9'h000;
      b_v[k] = 7'h00;
    end
  endtask

  // One clock cycle: drive, check against the model, update the model.
  task automatic step(input bit iv, input bit ordy);
    bit exp_rdy;
    bit exp_ov;
    int e;
    bus.in_valid     = iv;
    bus.out_ready    = ordy;
    bus.ha_array_0_t = t_v[0];
    bus.ha_array_1_t = t_v[1];
    bus.ha_array_2_t = t_v[2];
    bus.ha_array_3_t = t_v[3];
    bus.ha_array_0_b = b_v[0];
    bus.ha_array_1_b = b_v[1];
    bus.ha_array_2_b = b_v[2];
    bus.ha_array_3_b = b_v[3];
    #1;
    exp_rdy = (exp_q.size() < 2) || ordy;
    exp_ov  = (exp_q.size() == 2) || (exp_q.size() == 1 && !acc_last);
    check_val("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
    if (exp_ov) begin
      e = exp_q[0];
      check_val("out_p", {16'd0, bus.out_p}, {16'd0, e[15:0]});
      check_val("out_ovf", {31'd0, bus.out_ovf}, {31'd0, (e >= 65536)});
      if (ordy) void'(exp_q.pop_front());
    end
    acc_last = iv && exp_rdy;
    if (acc_last) exp_q.push_back(ref_sum());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_last = 1'b0;
    check_val("rst_out_p", {16'd0, bus.out_p}, 32'd0);
    check_val("rst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_val("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int acc_total;
    int cyc;
    err_cnt  = 0;
    chk_cnt  = 0;
    acc_last = 1'b0;
    clear_arrays();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    do_reset();

    // Single LSB.
    t_v[0] = 9'h001;
    step(1'b1, 1'b1);
    clear_arrays();
    drain();

    // Highest carry-row bit of array 3: weight 2^14.
    b_v[3] = 7'h40;
    step(1'b1, 1'b1);
    clear_arrays();
    drain();

    // All ones: 86615 wraps to 16'h5257 with the flag set.
    for (int k = 0; k < 4; k++) begin
      t_v[k] = 9'h1FF;
      b_v[k] = 7'h7F;
    end
    step(1'b1, 1'b1);
    clear_arrays();
    drain();

    // Backpressure: six stalled cycles offering 1, 2, then 3.
    t_v[0] = 9'h001;
    step(1'b1, 1'b0);
    t_v[0] = 9'h002;
    step(1'b1, 1'b0);
    t_v[0] = 9'h003;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check_val("bp_hold_p", {16'd0, bus.out_p}, 32'd1);
    check_val("bp_full", exp_q.size(), 32'd2);
    step(1'b1, 1'b1);
    clear_arrays();
    drain();

    // Reset with both stages full; nothing from before may reappear.
    t_v[1] = 9'h055;
    step(1'b1, 1'b0);
    t_v[2] = 9'h0AA;
    step(1'b1, 1'b0);
    clear_arrays();
    check_val("pre_rst_full", exp_q.size(), 32'd2);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

    // Random streaming.
    acc_total = 0;
    cyc = 0;
    while (acc_total < 10000 && cyc < 40000) begin
      for (int k = 0; k < 4; k++) begin
        t_v[k] = 9'($urandom_range(0, 511));
        b_v[k] = 7'($urandom_range(0, 127));
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if (acc_last) acc_total++;
      cyc++;
    end
    check_val("rand_accepted", acc_total, 32'd10000);
    clear_arrays();
    drain();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
